// File: rtl/status_branch_unit.sv
// Status register, sticky overflow and status-based branch decode behind the ALU.
// Define STATUS_TRAP_EN to build the overflow-trap FSM, the epc register and the trap handshake.
module status_branch_unit #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_n,
   input  logic            alu_v,
   input  logic            alu_z,
   input  logic            flag_we,
   input  logic            ovf_trap,
   input  logic [PC_W-1:0] pc,
   input  logic [2:0]      br_op,
   input  logic            clr_sov,
   input  logic            trap_ack,
   output logic            stat_n,
   output logic            stat_v,
   output logic            stat_z,
   output logic            sov,
   output logic            br_taken,
   output logic            trap_req,
   output logic            stall,
   output logic [PC_W-1:0] epc
);

   typedef struct packed {
      logic n;
      logic v;
      logic z;
   } flags_t;

   flags_t stat_q, stat_d;
   logic   sov_q, sov_d;

   always_comb begin
      stat_d = stat_q;
      if (flag_we) stat_d = '{n: alu_n, v: alu_v, z: alu_z};
      sov_d = sov_q;
      if (clr_sov) sov_d = 1'b0;
      if (flag_we && alu_v) sov_d = 1'b1;  // set beats clear
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_q <= '0;
         sov_q  <= 1'b0;
      end else begin
         stat_q <= stat_d;
         sov_q  <= sov_d;
      end
   end

   assign stat_n = stat_q.n;
   assign stat_v = stat_q.v;
   assign stat_z = stat_q.z;
   assign sov    = sov_q;

   // Decodes registered flags only: a same-cycle write is not bypassed.
   always_comb begin
      br_taken = 1'b0;
      case (br_op)
         3'b000: br_taken = 1'b0;
         3'b001: br_taken = stat_q.z;
         3'b010: br_taken = ~stat_q.z;
         3'b011: br_taken = stat_q.n;
         3'b100: br_taken = ~stat_q.n & ~stat_q.z;
         3'b101: br_taken = stat_q.v;
         3'b110: br_taken = sov_q;
         default: br_taken = 1'b1;
      endcase
   end

`ifdef STATUS_TRAP_EN
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic            trap_req_q, trap_req_d;
   logic            stall_q, stall_d;
   logic            trap_evt;

   assign trap_evt = flag_we & ovf_trap & alu_v;

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      case (state_q)
         IDLE: if (trap_evt) begin
            state_d = REQ;
            epc_d   = pc;
         end
         REQ:     if (trap_ack) state_d = DRAIN;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      trap_req_d = (state_d == REQ);
      stall_d    = (state_d == REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         epc_q      <= '0;
         trap_req_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         epc_q      <= epc_d;
         trap_req_q <= trap_req_d;
         stall_q    <= stall_d;
      end
   end

   assign trap_req = trap_req_q;
   assign stall    = stall_q;
   assign epc      = epc_q;
`else
   logic unused_trap_in;
   assign unused_trap_in = ^{ovf_trap, trap_ack, pc};

   assign trap_req = 1'b0;
   assign stall    = 1'b0;
   assign epc      = '0;
`endif

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed bench for status_branch_unit; trap checks follow the STATUS_TRAP_EN build.
module tb_status_branch_unit;
   localparam int PC_W = 32;

   logic            clk = 1'b0;
   logic            reset, alu_n, alu_v, alu_z, flag_we, ovf_trap, clr_sov, trap_ack;
   logic [PC_W-1:0] pc;
   logic [2:0]      br_op;
   logic            stat_n, stat_v, stat_z, sov, br_taken, trap_req, stall;
   logic [PC_W-1:0] epc;

   int checks = 0;
   int failures = 0;

   status_branch_unit #(.PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
      .flag_we(flag_we), .ovf_trap(ovf_trap), .pc(pc), .br_op(br_op),
      .clr_sov(clr_sov), .trap_ack(trap_ack), .stat_n(stat_n), .stat_v(stat_v),
      .stat_z(stat_z), .sov(sov), .br_taken(br_taken), .trap_req(trap_req),
      .stall(stall), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic [2:0] op, input logic exp, input string tag);
      br_op = op;
      #1;
      chk(tag, {31'b0, br_taken}, {31'b0, exp});
   endtask

   initial begin
      reset = 1'b1; alu_n = 0; alu_v = 0; alu_z = 0; flag_we = 0; ovf_trap = 0;
      clr_sov = 0; trap_ack = 0; pc = '0; br_op = 3'b000;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_flags", {29'b0, stat_n, stat_v, stat_z}, 32'd0);
      chk("rst_sov", {31'b0, sov}, 32'd0);
      chk("rst_trap_req", {31'b0, trap_req}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      br(3'b111, 1'b1, "br_always");
      br(3'b000, 1'b0, "br_never");

      // zero write: same-cycle branch sees old Z
      flag_we = 1; alu_z = 1; alu_n = 0;
      br(3'b001, 1'b0, "br_z_nobypass");
      step();
      flag_we = 0;
      br(3'b001, 1'b1, "br_z_next");
      br(3'b010, 1'b0, "br_nz");

      // negative
      flag_we = 1; alu_n = 1; alu_z = 0;
      step();
      flag_we = 0;
      br(3'b100, 1'b0, "br_gt_neg");
      br(3'b011, 1'b1, "br_n");
      alu_n = 0; alu_z = 1; alu_v = 1;
      step();
      chk("hold_flags", {29'b0, stat_n, stat_v, stat_z}, 32'b100);
      chk("hold_sov", {31'b0, sov}, 32'd0);

      // overflow without trap
      flag_we = 1; alu_v = 1; alu_n = 0; alu_z = 0; ovf_trap = 0;
      step();
      flag_we = 0;
      chk("ovf_stat_v", {31'b0, stat_v}, 32'd1);
      chk("ovf_sov", {31'b0, sov}, 32'd1);
      chk("ovf_no_trap", {31'b0, trap_req}, 32'd0);
      br(3'b101, 1'b1, "br_v");
      br(3'b100, 1'b1, "br_gt_pos");
      flag_we = 1; alu_v = 0;
      step();
      chk("v_clear_stat", {31'b0, stat_v}, 32'd0);
      chk("v_clear_sov_sticky", {31'b0, sov}, 32'd1);
      alu_v = 1; clr_sov = 1;
      step();
      chk("sov_set_wins", {31'b0, sov}, 32'd1);
      flag_we = 0;
      step();
      clr_sov = 0;
      chk("sov_cleared", {31'b0, sov}, 32'd0);
      br(3'b110, 1'b0, "br_sov0");

`ifdef STATUS_TRAP_EN
      flag_we = 1; ovf_trap = 1; alu_v = 1; pc = 32'h40;
      step();
      flag_we = 0; ovf_trap = 0;
      chk("trap_req_up", {31'b0, trap_req}, 32'd1);
      chk("trap_stall_up", {31'b0, stall}, 32'd1);
      chk("trap_epc", epc, 32'h40);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("trap_req_hold", {31'b0, trap_req}, 32'd1);
      end
      flag_we = 1; ovf_trap = 1; pc = 32'h44;
      step();
      flag_we = 0; ovf_trap = 0;
      chk("epc_no_relatch", epc, 32'h40);
      chk("req_after_2nd", {31'b0, trap_req}, 32'd1);
      trap_ack = 1;
      step();
      trap_ack = 0;
      chk("drain_req", {31'b0, trap_req}, 32'd0);
      chk("drain_stall", {31'b0, stall}, 32'd0);
      flag_we = 1; ovf_trap = 1; pc = 32'h4c;
      step();
      flag_we = 0; ovf_trap = 0;
      chk("drain_evt_ignored", {31'b0, trap_req}, 32'd0);
      chk("drain_epc_hold", epc, 32'h40);
      flag_we = 1; ovf_trap = 1; pc = 32'h48;
      step();
      flag_we = 0; ovf_trap = 0;
      chk("idle_retrap", {31'b0, trap_req}, 32'd1);
      chk("idle_retrap_epc", epc, 32'h48);
      reset = 1;
      step();
      reset = 0;
      chk("midrst_req", {31'b0, trap_req}, 32'd0);
      chk("midrst_stall", {31'b0, stall}, 32'd0);
      chk("midrst_epc", epc, 32'd0);
      chk("midrst_sov", {31'b0, sov}, 32'd0);
      chk("midrst_flags", {29'b0, stat_n, stat_v, stat_z}, 32'd0);
`else
      flag_we = 1; ovf_trap = 1; alu_v = 1; pc = 32'h40;
      step();
      flag_we = 0; ovf_trap = 0;
      chk("off_trap_req", {31'b0, trap_req}, 32'd0);
      chk("off_stall", {31'b0, stall}, 32'd0);
      chk("off_epc", epc, 32'd0);
      chk("off_sov", {31'b0, sov}, 32'd1);
      trap_ack = 1;
      step();
      trap_ack = 0;
      chk("off_ack_ignored", {31'b0, trap_req}, 32'd0);
      reset = 1;
      step();
      reset = 0;
      chk("off_rst_sov", {31'b0, sov}, 32'd0);
      chk("off_rst_flags", {29'b0, stat_n, stat_v, stat_z}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/status_branch_unit.md
# status_branch_unit

Captures the ALU condition outputs (negative, overflow, zero) into an architectural status register. It evaluates status-based branch conditions for the next instruction and runs an overflow-trap handshake toward the control unit. It sits directly downstream of the 32-bit ALU: the ALU's `n`, `v` and `zout` feed this block, and its `br_taken`, `trap_req` and `stall` outputs go to PC-select and control logic.

## Interface
- `PC_W`, default 32: width of the PC/EPC path.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `alu_n` in 1: ALU negative flag (`sum[31]`).
- `alu_v` in 1: ALU signed-overflow flag.
- `alu_z` in 1: ALU zero flag.
- `flag_we` in 1: current instruction writes the status register.
- `ovf_trap` in 1: current instruction traps on overflow (trapping add/sub); ignored unless `flag_we`.
- `pc` in `PC_W`: PC of the current instruction.
- `br_op` in 3: branch condition select.
- `clr_sov` in 1: clear sticky overflow.
- `trap_ack` in 1: control unit has taken the trap.
- `stat_n`, `stat_v`, `stat_z` out 1 each: registered status flags.
- `sov` out 1: sticky overflow.
- `br_taken` out 1: selected condition is true.
- `trap_req` out 1: overflow trap pending.
- `stall` out 1: freeze the pipeline/PC.
- `epc` out `PC_W`: PC of the trapping instruction.

## Operation
- **Status register:** when `flag_we`=1, on the clock edge `{stat_n,stat_v,stat_z} <= {alu_n,alu_v,alu_z}`; otherwise the register holds.
- **Sticky overflow:**
  - Set when `flag_we & alu_v`.
  - Cleared when `clr_sov`.
  - If set and clear occur in the same cycle, set wins.
- **Branch condition:** `br_taken` is combinational from the *registered* flags. Decode of `br_op`:
  - 000: 0
  - 001: Z
  - 010: ~Z
  - 011: N
  - 100: ~N & ~Z
  - 101: V
  - 110: `sov`
  - 111: 1
- **Trap FSM** (only with `STATUS_TRAP_EN`), states IDLE, REQ, DRAIN:
  - **Trap event:** `flag_we & ovf_trap & alu_v`.
  - **IDLE:** on a trap event, go to REQ and latch `epc <= pc`. Otherwise stay.
  - **REQ:** `trap_req`=1 and `stall`=1. On `trap_ack`, go to DRAIN. Otherwise stay.
  - **DRAIN:** one cycle with `trap_req`=0 and `stall`=0. Trap events in this cycle are ignored. Always returns to IDLE.
- Trap events in REQ or DRAIN do not relatch `epc` or change state. The status register and `sov` still update.
- `trap_ack` outside REQ is ignored.
- `epc` holds its value until the next accepted trap.

## Timing
- **Reset values:** `stat_n`=`stat_v`=`stat_z`=0, `sov`=0, `epc`=0, FSM=IDLE, `trap_req`=0, `stall`=0.
- **Status latency:** flags written in cycle t are visible on `stat_*` and affect `br_taken` in cycle t+1. There is no bypass, so a branch in the same cycle sees the old flags.
- **`br_taken`:** zero-cycle combinational path from `br_op` and the registered flags.
- **`trap_req`/`stall`:** registered. A trap event in cycle t raises them in cycle t+1.
- **Handshake:**
  - `trap_ack` sampled high in cycle k drops `trap_req` in cycle k+1 (DRAIN).
  - IDLE is reached in cycle k+2.
  - The earliest next accepted trap event is in cycle k+2.
- **Reset mid-operation:** reset in REQ or DRAIN returns to IDLE next edge with all outputs at reset values. A pending trap is discarded.

## Configuration
- **`STATUS_TRAP_EN` defined:** the trap FSM, `epc` register and handshake are built as described.
- **`STATUS_TRAP_EN` undefined:**
  - FSM and `epc` storage are removed.
  - `trap_req`=0, `stall`=0 and `epc`=0 constantly.
  - `ovf_trap` and `trap_ack` are ignored.
  - Status register, `sov` and `br_taken` are unchanged.

## Test plan
- Reset, then check outputs: all flags, `sov`, `trap_req`, `stall` and `epc` read 0. `br_op`=111 gives `br_taken`=1; `br_op`=000 gives 0.
- Write flags with `flag_we`=1, `alu_z`=1, `alu_n`=0, `br_op`=001:
  - In the same cycle `br_taken` reflects the old Z=0.
  - Next cycle `br_taken`=1.
  - `br_op`=010 then gives 0.
- Negative case: `alu_n`=1, `alu_z`=0 written, then `br_op`=100 gives 0 and `br_op`=011 gives 1. A later `flag_we`=0 with different ALU flags leaves the status unchanged.
- Overflow without trap: `alu_v`=1, `flag_we`=1, `ovf_trap`=0 sets `stat_v`=1 and `sov`=1 with no `trap_req`. Next write with `alu_v`=0 gives `stat_v`=0, `sov`=1. `clr_sov` together with a new overflow keeps `sov`=1; `clr_sov` alone clears it.
- Trap handshake (with macro): trap event at `pc`=0x0000_0040.
  - Next cycle: `trap_req`=`stall`=1 and `epc`=0x40.
  - Hold `trap_ack`=0 for 3 cycles; the request persists.
  - A second trap at `pc`=0x44 during REQ leaves `epc`=0x40.
  - `trap_ack`=1 gives DRAIN (`trap_req`=0), then IDLE.
- Reset mid-trap and macro-off build:
  - Assert `reset` during REQ: next cycle all outputs are 0.
  - Rebuild without `STATUS_TRAP_EN` and repeat the trap event: `trap_req`, `stall` and `epc` stay 0, while `sov` still sets.
